// File: rtl/reg_bank_write_arbiter.sv
// Round-robin write scheduler: grants one requester at a time to a shared
// bank of enable-gated registers, with a fixed IDLE -> WRITE -> ACK sequence.
module reg_bank_write_arbiter #(
    parameter int N_REQ  = 4,
    parameter int WIDTH  = 8,
    parameter int N_REGS = 8,
    localparam int AW    = $clog2(N_REGS),
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*AW-1:0]    req_addr,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       ack,
    output logic [N_REGS-1:0]      reg_en,
    output logic [WIDTH-1:0]       reg_d,
    output logic                   busy,
    output logic [IW-1:0]          grant_id
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IW-1:0]     r_grant;
    logic [IW-1:0]     r_last;
    logic [AW-1:0]     r_addr;
    logic [WIDTH-1:0]  r_data;

    logic              w_found;
    logic [IW-1:0]     w_win;
    logic [IW-1:0]     w_idx;

    // Search starts one past the last completed grant and takes the first set bit.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            w_idx = IW'((32'(r_last) + k) % 32'(N_REQ));
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ack         = '0;
        reg_en      = '0;
        reg_d       = '0;
        busy        = (r_state != S_IDLE);
        grant_id    = r_grant;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                reg_en[r_addr] = 1'b1;
                reg_d          = r_data;
                w_state_nxt    = S_ACK;
            end
            S_ACK: begin
                ack[r_grant] = 1'b1;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Inputs are latched only on arbitration; priority rotates only on a completed ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant <= '0;
            r_last  <= IW'(N_REQ - 1);
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            if (r_state == S_IDLE && w_found) begin
                r_grant <= w_win;
                r_addr  <= req_addr[int'(w_win)*AW +: AW];
                r_data  <= req_data[int'(w_win)*WIDTH +: WIDTH];
            end
            if (r_state == S_ACK) begin
                r_last <= r_grant;
            end
        end
    end

endmodule

// File: doc/reg_bank_write_arbiter.md
# reg_bank_write_arbiter

Round-robin write scheduler that shares one bank of enable-gated D registers among several requesters. Each requester presents an address and data with a req/ack handshake. The block grants one requester at a time, drives the bank's per-register enable lines and shared data bus for exactly one cycle, then acknowledges. It sits between the control logic that produces register updates and the register bank, which is instantiated externally and clocked on the same clk.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, register data width
- N_REGS, 8, registers in bank (power of two)
- AW, log2(N_REGS), register address width (derived)
- IW, log2(N_REQ), requester index width (derived)

- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- req  in  N_REQ  per-requester write request, level
- req_addr  in  N_REQ*AW  packed addresses, requester i at [i*AW +: AW]
- req_data  in  N_REQ*WIDTH  packed data, requester i at [i*WIDTH +: WIDTH]
- ack  out  N_REQ  one-cycle completion pulse, one-hot or zero
- reg_en  out  N_REGS  bank write enables, one-hot or zero
- reg_d  out  WIDTH  bank write data
- busy  out  1  high whenever state != IDLE
- grant_id  out  IW  index of current grantee, valid while busy

## Operation
- Reset is synchronous, active-high, on clk.
- FSM states: IDLE, WRITE, ACK.
- IDLE: if any req bit is set, select a winner by round-robin. Search begins at last_grant+1 mod N_REQ and takes the first set bit. Latch the winner's index into grant_id, its address into addr_q and its data into data_q, then go to WRITE. With no request, stay in IDLE.
- WRITE: reg_en[addr_q]=1 and reg_d=data_q for one cycle. Unconditionally go to ACK.
- ACK: ack[grant_id]=1 for one cycle, last_grant<=grant_id, go to IDLE.
- Inputs are sampled only in IDLE. Changes to req, req_addr or req_data during WRITE or ACK have no effect on the transaction in flight.
- Requester protocol:
  - Hold req high with stable addr/data until ack is seen.
  - To stop, drop req in the cycle after ack.
  - Keeping req high requests another write, which competes normally in the next IDLE.
- Outputs are decoded from registered state only; no combinational path from inputs to outputs.
- reg_en and reg_d:
  - reg_en is zero in IDLE and ACK.
  - reg_d is data_q in WRITE and 0 otherwise.
- Reset value of every output: ack=0, reg_en=0, reg_d=0, busy=0, grant_id=0.
- Reset value of internal state: state=IDLE, last_grant=N_REQ-1 (requester 0 has first priority), addr_q=0, data_q=0.
- Reset asserted in any state:
  - Next cycle is IDLE with all outputs zero.
  - An in-flight WRITE or ACK is abandoned; no ack is issued for it.
  - If reset is sampled at the edge that would enter WRITE, reg_en never pulses.
- Reset and req high in the same cycle: reset wins and the request is not latched.

## Timing
- Request first sampled high at edge k (state IDLE):
  - busy and grant_id are valid from cycle k+1.
  - reg_en pulses in cycle k+1, so the bank captures at edge k+2.
  - ack pulses in cycle k+2.
  - Back in IDLE in cycle k+3; the earliest next arbitration is at edge k+3.
- Throughput: one write per 3 cycles, regardless of the number of requesters.
- Fairness: with all N_REQ requesting continuously, each requester is granted exactly once per N_REQ transactions. Worst-case wait is 3*N_REQ cycles.
- last_grant updates only in ACK; an abandoned transaction does not rotate priority.

## Test plan
- Single write: req=0001, addr0=5, data0=0xA5 → cycle+1 reg_en=0x20, reg_d=0xA5; cycle+2 ack=0001. Data is captured by bank reg 5.
- All requesters simultaneous after reset, addr_i=i, data_i=0x10+i → grants 0,1,2,3 in order. Each grant gives reg_en=1<<i with reg_d=0x10+i, and acks are spaced 3 cycles apart.
- Rotation: after a grant to requester 2, set req=0101 → requester 0 is granted first; then keep req=0101 → the next grant goes to requester 2 (wraps past 3).
- Input change mid-transaction: change data0 from 0x11 to 0x22 during WRITE → reg_d stays 0x11 and the bank stores 0x11.
- Reset in WRITE: assert reset for one cycle while reg_en is high → next cycle all outputs are 0 and no ack is issued. Requester 0 keeps req high; after reset drops, requester 0 is granted again.
- Idle hold: req=0 for 20 cycles → busy, reg_en and ack stay 0 throughout.
